// File: rtl/dcache_tag_array.sv
// dcache_tag_array
// N-way set-associative tag store for the data cache. Each (set, way) entry
// holds a tag, a valid bit and a dirty bit; each set also holds WAYS-1 bits
// of tree pseudo-LRU state. A lookup compares the request tag against every
// way of the addressed set in parallel and returns registered hit and victim
// information one cycle later. A sweep sequencer clears every valid, dirty
// and PLRU bit after reset and on an invalidate-all request.
//
// Ports
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   inv_all_i             start an invalidate-all sweep (sampled when ready_o=1)
//   ready_o               array accepts lookups and writes
//   req_i/req_idx_i/req_tag_i               lookup request
//   rsp_valid_o           one-cycle pulse, lookup result valid
//   hit_o/hit_way_o       hit flag and hitting way (0 on miss)
//   victim_way_o/victim_valid_o/victim_dirty_o/victim_tag_o
//                         replacement way for the looked-up set and its fields
//   wr_i/wr_idx_i/wr_way_i/wr_tag_i/wr_valid_i/wr_dirty_i
//                         single-entry write
module dcache_tag_array #(
    parameter int WAYS  = 2,
    parameter int SETS  = 32,
    parameter int TAG_W = 22,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inv_all_i,
    output logic             ready_o,
    input  logic             req_i,
    input  logic [IDX_W-1:0] req_idx_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    output logic             hit_o,
    output logic [WAY_W-1:0] hit_way_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             victim_valid_o,
    output logic             victim_dirty_o,
    output logic [TAG_W-1:0] victim_tag_o,
    input  logic             wr_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WAY_W-1:0] wr_way_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_valid_i,
    input  logic             wr_dirty_i
);

    localparam int LVLS   = $clog2(WAYS);
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    // Tree PLRU, heap-ordered nodes 1..WAYS-1 stored at bit node-1.
    // A node bit of 0 steers the victim search left, 1 steers it right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [7:0] b;
        int node;
        b    = 8'(bits);
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + (b[3'(node - 1)] ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Walk the path to `way` and make every node on it point the other way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [7:0] b;
        logic [2:0] w;
        logic       dir;
        int node;
        b    = 8'(bits);
        w    = 3'(way);
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            dir = w[3'(LVLS - 1 - l)];
            b[3'(node - 1)] = ~dir;
            node = 2 * node + (dir ? 1 : 0);
        end
        return PLRU_W'(b);
    endfunction

    // ---------------- sweep sequencer ----------------
    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == IDX_W'(SETS - 1)) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (inv_all_i) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    logic sweep;
    logic lookup_go;
    logic write_go;

    assign ready_o   = (state_reg == ST_IDLE);
    assign sweep     = (state_reg == ST_INIT);
    assign lookup_go = req_i & ready_o;
    assign write_go  = wr_i & ready_o;

    // ---------------- per-way storage ----------------
    logic [WAYS-1:0][TAG_W-1:0] rd_tag;
    logic [WAYS-1:0]            rd_valid;
    logic [WAYS-1:0]            rd_dirty;

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [TAG_W-1:0] tag_mem   [SETS];
        logic             valid_mem [SETS];
        logic             dirty_mem [SETS];

        always_ff @(posedge clk_i) begin
            if (sweep) begin
                valid_mem[cnt_reg] <= 1'b0;
                dirty_mem[cnt_reg] <= 1'b0;
            end else if (write_go && wr_way_i == WAY_W'(gi)) begin
                tag_mem[wr_idx_i]   <= wr_tag_i;
                valid_mem[wr_idx_i] <= wr_valid_i;
                dirty_mem[wr_idx_i] <= wr_dirty_i;
            end
        end

        // Read happens before this edge's write lands, giving read-old
        // behaviour for a same-cycle lookup and write.
        assign rd_tag[gi]   = tag_mem[req_idx_i];
        assign rd_valid[gi] = valid_mem[req_idx_i];
        assign rd_dirty[gi] = dirty_mem[req_idx_i];
    end

    // ---------------- PLRU storage ----------------
    logic [PLRU_W-1:0] plru_mem [SETS];
    logic [PLRU_W-1:0] plru_req;
    logic [PLRU_W-1:0] plru_wr;

    assign plru_req = plru_mem[req_idx_i];
    assign plru_wr  = plru_mem[wr_idx_i];

    // ---------------- compare and victim select ----------------
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim_way;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && rd_valid[w] && rd_tag[w] == req_tag_i) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !rd_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : plru_victim(plru_req);
    end

    // A same-set write update is issued last so it overrides the hit update.
    always_ff @(posedge clk_i) begin
        if (sweep) begin
            plru_mem[cnt_reg] <= '0;
        end else if (WAYS > 1) begin
            if (lookup_go && hit)         plru_mem[req_idx_i] <= plru_touch(plru_req, hit_way);
            if (write_go && wr_valid_i)   plru_mem[wr_idx_i]  <= plru_touch(plru_wr, wr_way_i);
        end
    end

    // ---------------- registered response ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o    <= 1'b0;
            hit_o          <= 1'b0;
            hit_way_o      <= '0;
            victim_way_o   <= '0;
            victim_valid_o <= 1'b0;
            victim_dirty_o <= 1'b0;
            victim_tag_o   <= '0;
        end else begin
            rsp_valid_o <= lookup_go;
            if (lookup_go) begin
                hit_o          <= hit;
                hit_way_o      <= hit_way;
                victim_way_o   <= victim_way;
                victim_valid_o <= rd_valid[victim_way];
                victim_dirty_o <= rd_dirty[victim_way];
                victim_tag_o   <= rd_tag[victim_way];
            end
        end
    end

endmodule

// File: tb/tb_dcache_tag_array.sv
// Testbench for dcache_tag_array (WAYS=2, SETS=32, TAG_W=22).
// Stimulus pushes expected lookup results into a queue; a monitor process
// pops and compares whenever rsp_valid_o is seen. The reference model keeps
// per-entry tag/valid/dirty and the most recently used way per set.
module tb_dcache_tag_array;

    localparam int WAYS = 2, SETS = 32, TAG_W = 22;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        inv_all_i = 1'b0;
    logic        ready_o;
    logic        req_i = 1'b0;
    logic [4:0]  req_idx_i = '0;
    logic [21:0] req_tag_i = '0;
    logic        rsp_valid_o;
    logic        hit_o;
    logic [0:0]  hit_way_o;
    logic [0:0]  victim_way_o;
    logic        victim_valid_o;
    logic        victim_dirty_o;
    logic [21:0] victim_tag_o;
    logic        wr_i = 1'b0;
    logic [4:0]  wr_idx_i = '0;
    logic [0:0]  wr_way_i = '0;
    logic [21:0] wr_tag_i = '0;
    logic        wr_valid_i = 1'b0;
    logic        wr_dirty_i = 1'b0;

    dcache_tag_array #(.WAYS(WAYS), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .inv_all_i(inv_all_i), .ready_o(ready_o),
        .req_i(req_i), .req_idx_i(req_idx_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .hit_o(hit_o), .hit_way_o(hit_way_o),
        .victim_way_o(victim_way_o), .victim_valid_o(victim_valid_o),
        .victim_dirty_o(victim_dirty_o), .victim_tag_o(victim_tag_o),
        .wr_i(wr_i), .wr_idx_i(wr_idx_i), .wr_way_i(wr_way_i), .wr_tag_i(wr_tag_i),
        .wr_valid_i(wr_valid_i), .wr_dirty_i(wr_dirty_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        hit;
        bit        hit_way;
        bit        vway;
        bit        vvalid;
        bit        vdirty;
        bit [21:0] vtag;
        bit        tag_known;
        int        idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    bit [21:0] m_tag   [SETS][WAYS];
    bit        m_known [SETS][WAYS];
    bit        m_valid [SETS][WAYS];
    bit        m_dirty [SETS][WAYS];
    int        m_mru   [SETS];
    int        sweep_left = 0;

    function automatic void clear_model();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_mru[s] = 1;   // cleared PLRU points at way 0
        end
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.hit = 0; e.hit_way = 0; e.vway = 0; e.vvalid = 0; e.vdirty = 0;
        e.vtag = '0; e.tag_known = 1; e.idx = 0;
        return e;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0b, required %0b at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus; inputs are applied at the falling edge.
    task automatic step(input bit req, input int idx, input bit [21:0] tag,
                        input bit wr, input int widx, input int wway, input bit [21:0] wtag,
                        input bit wv, input bit wd, input bit inv);
        exp_t e;
        int   v;
        bit   accept;
        @(negedge clk_i);
        accept = (sweep_left == 0);
        check_bit("ready", ready_o, accept);
        req_i = req;  req_idx_i = 5'(idx);  req_tag_i = tag;
        wr_i = wr;    wr_idx_i = 5'(widx);  wr_way_i = 1'(wway);
        wr_tag_i = wtag; wr_valid_i = wv; wr_dirty_i = wd;
        inv_all_i = inv;
        if (accept && req) begin
            e.hit = 0; e.hit_way = 0; e.idx = idx;
            for (int w = WAYS - 1; w >= 0; w--) begin
                if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
                    e.hit = 1; e.hit_way = 1'(w);
                end
            end
            if (!m_valid[idx][0])      v = 0;
            else if (!m_valid[idx][1]) v = 1;
            else                       v = 1 - m_mru[idx];
            e.vway = 1'(v);
            e.vvalid = m_valid[idx][v];
            e.vdirty = m_dirty[idx][v];
            e.vtag = m_tag[idx][v];
            e.tag_known = m_known[idx][v];
            exp_q.push_back(e);
            if (e.hit) m_mru[idx] = e.hit_way;
        end
        if (accept && wr) begin
            m_tag[widx][wway] = wtag;
            m_known[widx][wway] = 1'b1;
            m_valid[widx][wway] = wv;
            m_dirty[widx][wway] = wd;
            if (wv) m_mru[widx] = wway;
        end
        @(posedge clk_i);
        if (accept && inv) begin
            sweep_left = SETS;
            clear_model();
        end else if (sweep_left > 0) begin
            sweep_left--;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic lookup(input int idx, input bit [21:0] tag);
        step(1, idx, tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic write(input int idx, input int way, input bit [21:0] tag, input bit v, input bit d);
        step(0, 0, 0, 1, idx, way, tag, v, d, 0);
    endtask

    // Assert reset away from any edge, check outputs at once, release.
    task automatic do_reset(input int hold);
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_bit("rst_ready", ready_o, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid_o, 1'b0);
        check_bit("rst_hit", hit_o, 1'b0);
        check_bit("rst_hit_way", hit_way_o, 1'b0);
        check_bit("rst_victim_way", victim_way_o, 1'b0);
        check_bit("rst_victim_valid", victim_valid_o, 1'b0);
        check_bit("rst_victim_dirty", victim_dirty_o, 1'b0);
        n_cmp++;
        if (victim_tag_o !== 22'h0) begin
            n_bad++;
            $display("FAIL rst_victim_tag: got %h, required 0", victim_tag_o);
        end
        exp_q.delete();
        last_exp = zero_exp();
        clear_model();
        req_i = 0; wr_i = 0; inv_all_i = 0;
        repeat (hold) @(negedge clk_i);
        rst_n_i = 1'b1;
        sweep_left = SETS;
        @(posedge clk_i);
        sweep_left--;
    endtask

    // monitor / scoreboard
    initial begin
        exp_t e;
        bit   ok;
        last_exp = zero_exp();
        forever begin
            @(negedge clk_i);
            if (rst_n_i && rsp_valid_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rsp: rsp_valid_o=1, required no response at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    ok = (hit_o === e.hit) && (hit_way_o === e.hit_way) &&
                         (victim_way_o === e.vway) && (victim_valid_o === e.vvalid) &&
                         (victim_dirty_o === e.vdirty) &&
                         (!e.tag_known || victim_tag_o === e.vtag);
                    if (!ok) begin
                        n_bad++;
                        $display("FAIL lookup set %0d: got hit=%0b way=%0b vway=%0b vv=%0b vd=%0b vtag=%h, required hit=%0b way=%0b vway=%0b vv=%0b vd=%0b vtag=%h",
                                 e.idx, hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o,
                                 e.hit, e.hit_way, e.vway, e.vvalid, e.vdirty, e.vtag);
                    end else begin
                        $display("rsp set %0d hit=%0b way=%0b vway=%0b vv=%0b vd=%0b vtag=%h",
                                 e.idx, hit_o, hit_way_o, victim_way_o, victim_valid_o, victim_dirty_o, victim_tag_o);
                    end
                    last_exp = e;
                end
            end else if (rst_n_i) begin
                // outputs hold their last values between responses
                n_cmp++;
                if (hit_o !== last_exp.hit || hit_way_o !== last_exp.hit_way ||
                    victim_way_o !== last_exp.vway || victim_valid_o !== last_exp.vvalid ||
                    victim_dirty_o !== last_exp.vdirty ||
                    (last_exp.tag_known && victim_tag_o !== last_exp.vtag)) begin
                    n_bad++;
                    $display("FAIL hold: got hit=%0b vway=%0b vv=%0b, required hit=%0b vway=%0b vv=%0b at %0t",
                             hit_o, victim_way_o, victim_valid_o, last_exp.hit, last_exp.vway, last_exp.vvalid, $time);
                end
            end
        end
    end

    // stimulus
    initial begin
        clear_model();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_known[s][w] = 1'b0;

        // reset release: ready low through the init sweep
        do_reset(3);
        repeat (31) idle();
        lookup(5, 22'h12345);

        // single write then hit, then miss prefers the invalid way
        write(5, 1, 22'h2AAAA, 1, 1);
        lookup(5, 22'h2AAAA);
        lookup(5, 22'h00003);

        // PLRU: fill set 3, touch way 0, miss evicts way 1
        write(3, 0, 22'h100, 1, 0);
        write(3, 1, 22'h200, 1, 0);
        lookup(3, 22'h100);
        lookup(3, 22'h999);

        // same-cycle write and lookup: read-old, then hit
        step(1, 7, 22'h55, 1, 7, 0, 22'h55, 1, 0, 0);
        lookup(7, 22'h55);

        // invalidate-all with a concurrent lookup
        write(0, 0, 22'h11, 1, 1);
        write(31, 1, 22'h31, 1, 1);
        write(0, 1, 22'h12, 1, 0);
        step(1, 0, 22'h11, 0, 0, 0, 0, 0, 0, 1);
        repeat (SETS) step(1, $urandom_range(0, 31), 22'h11, 1, 0, 0, 22'h77, 1, 1, 0);
        lookup(0, 22'h11);
        lookup(31, 22'h31);
        lookup(0, 22'h12);

        // reset during a sweep
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (10) idle();
        do_reset(2);
        repeat (31) idle();
        lookup(3, 22'h100);

        // randomized traffic on a few hot sets with a small tag pool
        for (int i = 0; i < 500; i++) begin
            int r_idx, w_idx;
            r_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3));
            w_idx = ($urandom_range(0, 3) == 0) ? r_idx : int'($urandom_range(0, 3));
            step($urandom_range(0, 2) != 0, r_idx, 22'($urandom_range(1, 6)),
                 $urandom_range(0, 2) == 0, w_idx, $urandom_range(0, 1),
                 22'($urandom_range(1, 6)), $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) == 0);
        end

        idle();
        idle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_rsp: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
